// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART serialiser.
// Bytes from the core or wrapper are queued in a small count-based FIFO and
// sent LSB first on uart_txd. The line idles high and is driven from a flop.
// Frames are sent back to back while uart_tx_en is high and bytes are queued.
// Optional build macro UART_TX_PARITY_EN: when defined, an even-parity bit
// follows the data bits (8E1). When it is undefined, frames are 8N1.
module uart_tx_fifo #(
  parameter int CLK_HZ       = 50000000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
  input  logic                    uart_tx_valid,
  output logic                    uart_tx_ready,
  output logic                    uart_tx_busy,
  output logic                    uart_tx_empty,
  output logic                    uart_txd
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int STOP_CYCLES    = STOP_BITS * CYCLES_PER_BIT;
  localparam int CNT_W          = $clog2(STOP_CYCLES + 1);
  localparam int PTR_W          = $clog2(FIFO_DEPTH);
  localparam int FCNT_W         = PTR_W + 1;
  localparam int BIT_W          = $clog2(PAYLOAD_BITS + 1);

  // Counter reload values: each slot counts down to zero, then the FSM advances.
  localparam logic [CNT_W-1:0]  BIT_LAST   = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  STOP_LAST  = CNT_W'(STOP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [BIT_W-1:0]  DATA_LAST  = BIT_W'(PAYLOAD_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_ZERO   = {BIT_W{1'b0}};
  localparam logic [BIT_W-1:0]  BIT_ONE    = BIT_W'(1);
  localparam logic [FCNT_W-1:0] FIFO_FULL  = FCNT_W'(FIFO_DEPTH);
  localparam logic [FCNT_W-1:0] FCNT_ZERO  = {FCNT_W{1'b0}};
  localparam logic [FCNT_W-1:0] FCNT_ONE   = FCNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ZERO   = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
  localparam logic [PAYLOAD_BITS-1:0] BYTE_ZERO = {PAYLOAD_BITS{1'b0}};

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [PAYLOAD_BITS-1:0] data);
    return ^data;
  endfunction
`endif

  // FIFO storage and bookkeeping
  logic [PAYLOAD_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [FCNT_W-1:0]       count_r;
  logic [FCNT_W-1:0]       count_nxt_s;
  logic                    ready_r;
  logic                    empty_r;
  logic                    push_s;
  logic                    pop_s;
  logic                    launch_s;
  logic                    slot_end_s;
  logic [PAYLOAD_BITS-1:0] head_s;

  // Serialiser state
  logic [2:0]              state_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [BIT_W-1:0]        bit_r;
  logic [PAYLOAD_BITS-1:0] shift_r;
  logic                    txd_r;
  logic                    busy_r;
`ifdef UART_TX_PARITY_EN
  logic                    parity_r;
`endif

  assign push_s     = uart_tx_valid && ready_r;
  assign launch_s   = uart_tx_en && !empty_r;
  assign slot_end_s = (cnt_r == CNT_ZERO);
  assign head_s     = mem_r[rd_ptr_r];

  // A new frame may only be launched from IDLE or at the very end of STOP.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      S_IDLE:  pop_s = launch_s;
      S_STOP:  pop_s = slot_end_s && launch_s;
      default: pop_s = 1'b0;
    endcase
  end

  // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + FCNT_ONE;
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - FCNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // FIFO storage, pointers and registered ready/empty flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= BYTE_ZERO;
      end
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= FCNT_ZERO;
      ready_r  <= 1'b1;
      empty_r  <= 1'b1;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= uart_tx_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
      ready_r <= (count_nxt_s != FIFO_FULL);
      empty_r <= (count_nxt_s == FCNT_ZERO);
    end
  end

  // Frame sequencer: START, DATA (LSB first), optional PARITY, STOP.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r  <= S_IDLE;
      cnt_r    <= CNT_ZERO;
      bit_r    <= BIT_ZERO;
      shift_r  <= BYTE_ZERO;
      txd_r    <= 1'b1;
      busy_r   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (pop_s) begin
            shift_r  <= head_s;
`ifdef UART_TX_PARITY_EN
            parity_r <= even_parity(head_s);
`endif
            cnt_r    <= BIT_LAST;
            txd_r    <= 1'b0;
            busy_r   <= 1'b1;
            state_r  <= S_START;
          end else begin
            txd_r    <= 1'b1;
            busy_r   <= 1'b0;
          end
        end
        S_START: begin
          if (slot_end_s) begin
            txd_r   <= shift_r[0];
            shift_r <= shift_r >> 1;
            bit_r   <= BIT_ZERO;
            cnt_r   <= BIT_LAST;
            state_r <= S_DATA;
          end else begin
            cnt_r   <= cnt_r - CNT_ONE;
          end
        end
        S_DATA: begin
          if (slot_end_s) begin
            if (bit_r == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
              txd_r   <= parity_r;
              cnt_r   <= BIT_LAST;
              state_r <= S_PARITY;
`else
              txd_r   <= 1'b1;
              cnt_r   <= STOP_LAST;
              state_r <= S_STOP;
`endif
            end else begin
              txd_r   <= shift_r[0];
              shift_r <= shift_r >> 1;
              bit_r   <= bit_r + BIT_ONE;
              cnt_r   <= BIT_LAST;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (slot_end_s) begin
            txd_r   <= 1'b1;
            cnt_r   <= STOP_LAST;
            state_r <= S_STOP;
          end else begin
            cnt_r   <= cnt_r - CNT_ONE;
          end
        end
`endif
        S_STOP: begin
          if (slot_end_s) begin
            if (pop_s) begin
              // Next byte already waiting: go straight into its start bit.
              shift_r  <= head_s;
`ifdef UART_TX_PARITY_EN
              parity_r <= even_parity(head_s);
`endif
              cnt_r    <= BIT_LAST;
              txd_r    <= 1'b0;
              busy_r   <= 1'b1;
              state_r  <= S_START;
            end else begin
              txd_r    <= 1'b1;
              busy_r   <= 1'b0;
              state_r  <= S_IDLE;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_r <= S_IDLE;
          cnt_r   <= CNT_ZERO;
          txd_r   <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign uart_tx_ready = ready_r;
  assign uart_tx_empty = empty_r;
  assign uart_tx_busy  = busy_r;
  assign uart_txd      = txd_r;

endmodule
